// File: rtl/sync_debounce.sv
// Input conditioning: SYNC_STAGES-deep synchronizer feeding a debounce FSM that
// accepts a new level only after DEBOUNCE_CYCLES consecutive matching samples.
module sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dout_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  // Plain shift chain: nothing may sit between the flops, or metastability
  // resolution time is lost.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so they can only ever be one cycle wide.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_q <= LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            dout_q  <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Input conditioning stage that takes an asynchronous, possibly bouncing single-bit input (pushbutton, switch, external strobe) and produces a clean, clock-synchronous level plus one-cycle rise/fall strobes. It sits directly upstream of the registered-data flops in the design: its `dout` drives their `d` inputs, and `rise`/`fall` serve as single-cycle enables. Design is a multi-stage synchronizer followed by a debounce FSM with a stability counter.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a new level; legal ≥ 2.
- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  reset, asynchronous, active-high; one clock, no other clock domains.
- `din`  input  1  raw asynchronous input; no timing relation to `clk`.
- `dout`  output  1  debounced registered level.
- `rise`  output  1  one-cycle pulse on accepted 0→1 of `dout`.
- `fall`  output  1  one-cycle pulse on accepted 1→0 of `dout`.
- `busy`  output  1  high while a candidate transition is being qualified.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series, first flop samples `din`. The last stage output is `s`. No logic between synchronizer flops.
- Counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide. It is cleared whenever the FSM enters a stable state.
- FSM states: `LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`.
- `LOW`: when `s`=1, go to `WAIT_HIGH` with `cnt`=1. Otherwise stay.
- `WAIT_HIGH` with `s`=1: if `cnt`==`DEBOUNCE_CYCLES`-1, go to `HIGH`; otherwise increment `cnt`.
- `WAIT_HIGH` with `s`=0: return to `LOW`, clear `cnt`, emit no pulse.
- `HIGH` and `WAIT_LOW` mirror `LOW` and `WAIT_HIGH` with `s` inverted.
- `dout` is 1 exactly in `HIGH` and `WAIT_LOW`. It does not change during qualification.
- `rise` is registered and high only for the first cycle in `HIGH` after a `WAIT_HIGH` exit.
- `fall` is registered and high only for the first cycle in `LOW` after a `WAIT_LOW` exit.
- `rise` and `fall` are never high together. Neither is high in any cycle where `dout` did not change.
- `busy` = 1 in `WAIT_HIGH` and `WAIT_LOW`.
- Reset (asynchronous, immediate on `rst`=1):
  - All synchronizer flops 0, state `LOW`, `cnt` 0.
  - `dout`, `rise`, `fall`, `busy` all 0.
  - Reset mid-qualification discards progress.
- `din`=1 at reset release is treated as a normal 0→1 event. It produces `rise` after full latency.
- Counter never wraps. Qualification ends at `DEBOUNCE_CYCLES`-1 or on a mismatching sample.

## Timing
- Edge numbering: edge 0 is the first posedge at which the first sync flop captures a new `din` value that then holds steady.
- `s` takes the new value after edge `SYNC_STAGES`-1.
- `busy` rises after edge `SYNC_STAGES`.
- `dout` toggles and `rise`/`fall` assert after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`-1; `busy` falls after the same edge.
- Total latency is `SYNC_STAGES`+`DEBOUNCE_CYCLES` cycles. With defaults: `busy` after edge 2, output after edge 5.
- `rise`/`fall` deassert after the following edge; pulse width is exactly 1 cycle.
- Minimum accepted pulse width on `din`: `DEBOUNCE_CYCLES` cycles, as seen at `s`. Shorter pulses are fully rejected.
- Back-to-back transitions: a new opposite transition may begin qualifying on the cycle immediately after `rise`/`fall`.

## Test plan
- Reset: hold `rst`=1 with `din`=1 and toggle `clk` → `dout`=`rise`=`fall`=`busy`=0 throughout. Assert `rst` asynchronously between edges → outputs clear before the next edge.
- Clean rise (defaults), `din` 0→1 at edge 0 → `busy`=1 after edges 2–4. `dout`=1 and `rise`=1 after edge 5. `rise`=0 and `busy`=0 after edge 6. `fall` is never high.
- Glitch rejection: from `LOW`, `din`=1 for 3 cycles, then 0 → `busy` pulses, `dout` stays 0, `rise` never asserts, and the FSM returns to `LOW` with `cnt`=0.
- Clean fall from stable `HIGH`, `din` 1→0 at edge 0 → `dout`=0 and `fall`=1 after edge 5. `fall` lasts exactly 1 cycle.
- Reset mid-qualification: assert `rst` while `busy`=1 in `WAIT_HIGH` (after edge 3) → immediate all-zero outputs. After release with `din`=1 held, `rise` arrives a full 6 cycles after the first capturing edge.
- Bounce then settle: `din` pattern 1,0,1,1,0,1 followed by steady 1 → exactly one `rise` pulse, 6 cycles after the start of the steady-1 run at the sync input, and no `fall`.
